// File: rtl/memory_arbiter.sv
// Two-requester arbiter sharing one RAM port between instruction fetch and data access.
// Data wins by default; a starvation counter hands the port to fetch after STARVE_MAX data completions.
module memory_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam int GW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, nstate;
  logic [SW-1:0] starve;
  logic [GW-1:0] gcnt;
  logic          access, err, in_grant, d_req, req_held, tmo_hit;

  assign access   = (ramstate == RS_ACCESS);
  assign err      = (ramstate == RS_ERROR);
  assign in_grant = (state != IDLE);
  assign d_req    = dREN | dWEN;
  assign req_held = (state == IGNT) ? iREN : d_req;
  // The grant cycle that would push the counter to TIMEOUT ends the grant.
  assign tmo_hit  = in_grant && !access && (gcnt == GW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (d_req && ((starve < SW'(STARVE_MAX)) || !iREN)) nstate = DGNT;
        else if (iREN)                                      nstate = IGNT;
      end
      default: begin
        if (access || !req_held || err || tmo_hit) nstate = IDLE;
      end
    endcase
  end

  // Grants are always entered from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          gcnt <= '0;
    else if (!in_grant) gcnt <= '0;
    else if (!access)   gcnt <= gcnt + GW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        timeout_err <= 1'b0;
    else if (tmo_hit) timeout_err <= 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                   starve <= '0;
    else if (!iREN)                              starve <= '0;
    else if (state == IGNT && access)            starve <= '0;
    else if (state == DGNT && access && (starve < SW'(STARVE_MAX)))
                                                 starve <= starve + SW'(1);
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (dWEN) ramWEN = 1'b1;
        else      ramREN = 1'b1;
      end
      default: ;
    endcase
  end

  assign iwait = !(state == IGNT && access);
  assign dwait = !(state == DGNT && access);
  assign iload = ramload;
  assign dload = ramload;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a grant-owner reference model.
module tb_memory_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int ncmp = 0;
  int nbad = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), grant length,
  // data completions since the last fetch service, sticky timeout.
  int m_own, m_len, m_starve;
  bit m_terr;

  memory_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_len = 0; m_starve = 0; m_terr = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  done, held;
    if (!nRST) begin
      model_reset();
      return;
    end
    done = (m_own != 0) && (ramstate == 2'd2);
    nxt  = m_own;
    if (m_own == 0) begin
      m_len = 0;
      if ((dREN || dWEN) && (m_starve < STARVE_MAX || !iREN)) nxt = 2;
      else if (iREN)                                          nxt = 1;
    end else begin
      held = (m_own == 1) ? iREN : (dREN || dWEN);
      if (!done) begin
        m_len++;
        if (m_len == TIMEOUT) begin
          m_terr = 1;
          nxt = 0;
        end
      end
      if (done || !held || ramstate == 2'd3) nxt = 0;
    end
    if (!iREN)                    m_starve = 0;
    else if (m_own == 1 && done)  m_starve = 0;
    else if (m_own == 2 && done && m_starve < STARVE_MAX) m_starve++;
    m_own = nxt;
  endtask

  // Compare every output at the falling edge, then advance one clock.
  task automatic tick();
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    @(negedge CLK);
    e_ren   = (m_own == 1) || (m_own == 2 && !dWEN);
    e_wen   = (m_own == 2) && dWEN;
    e_addr  = (m_own == 1) ? iaddr : (m_own == 2) ? daddr : 32'h0;
    e_store = (m_own == 2) ? dstore : 32'h0;
    e_iw    = !(m_own == 1 && ramstate == 2'd2);
    e_dw    = !(m_own == 2 && ramstate == 2'd2);
    chk("ramREN",   32'(ramREN),      32'(e_ren));
    chk("ramWEN",   32'(ramWEN),      32'(e_wen));
    chk("ramaddr",  ramaddr,          e_addr);
    chk("ramstore", ramstore,         e_store);
    chk("iwait",    32'(iwait),       32'(e_iw));
    chk("dwait",    32'(dwait),       32'(e_dw));
    chk("tmo_err",  32'(timeout_err), 32'(m_terr));
    if (!e_iw) chk("iload", iload, ramload);
    if (!e_dw) chk("dload", dload, ramload);
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    int streak, mx, icnt, acc, r;
    nRST = 1'b0;
    model_reset();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;

    // Fetch with two BUSY cycles then ACCESS.
    do_reset();
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1; ramload = 32'h2108000A;
    tick();
    #1 chk("t1_ren", 32'(ramREN), 1); chk("t1_addr", ramaddr, 32'h40);
    chk("t1_iwait_busy", 32'(iwait), 1);
    tick();
    ramstate = 2'd2;
    #1 chk("t1_iwait", 32'(iwait), 0); chk("t1_iload", iload, 32'h2108000A);
    tick();
    #1 chk("t1_idle_ren", 32'(ramREN), 0);
    iREN = 0;
    tick();

    // Write wins over read.
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = 2'd2;
    tick();
    #1 chk("t2_wen", 32'(ramWEN), 1); chk("t2_ren", 32'(ramREN), 0);
    chk("t2_addr", ramaddr, 32'h80); chk("t2_store", ramstore, 32'hDEADBEEF);
    chk("t2_dwait", 32'(dwait), 0);
    dREN = 0; dWEN = 0;
    tick();

    // Timeout while RAM stays BUSY.
    do_reset();
    dREN = 1; ramstate = 2'd1;
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      #1 chk("t3_ren_hold", 32'(ramREN), 1);
      tick();
    end
    #1 chk("t3_idle", 32'(ramREN), 0); chk("t3_err", 32'(timeout_err), 1);
    chk("t3_dwait", 32'(dwait), 1);
    tick();
    #1 chk("t3_regrant", 32'(ramREN), 1);
    dREN = 0;
    tick();

    // Fetch request withdrawn during the grant.
    do_reset();
    iREN = 1; ramstate = 2'd1;
    tick();
    #1 chk("t4_ren", 32'(ramREN), 1);
    iREN = 0;
    tick();
    #1 chk("t4_drop_ren", 32'(ramREN), 0); chk("t4_drop_iwait", 32'(iwait), 1);

    // Reset pulsed in the middle of a data write grant.
    do_reset();
    dREN = 1; dWEN = 1; ramstate = 2'd1;
    tick(); tick();
    #1 chk("t4_wen_pre", 32'(ramWEN), 1);
    nRST = 1'b0;
    model_reset();
    #1 chk("t4_wen_rst", 32'(ramWEN), 0); chk("t4_gcnt", 32'(dut.gcnt), 0);
    chk("t4_starve", 32'(dut.starve), 0); chk("t4_dwait_rst", 32'(dwait), 1);
    tick();
    dREN = 0; dWEN = 0;
    nRST = 1'b1;
    tick();

    // ERROR aborts the grant; data re-arbitrated.
    do_reset();
    dREN = 1; ramstate = 2'd3;
    tick();
    #1 chk("t5_ren", 32'(ramREN), 1); chk("t5_dwait", 32'(dwait), 1);
    tick();
    #1 chk("t5_idle", 32'(ramREN), 0);
    ramstate = 2'd1;
    tick();
    #1 chk("t5_regrant", 32'(ramREN), 1);
    dREN = 0;
    tick();

    // Both requesters always asking: fetch gets in after STARVE_MAX data completions.
    do_reset();
    iREN = 1; dREN = 1; ramstate = 2'd2;
    streak = 0; mx = 0; icnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!dwait) streak++;
      if (!iwait) begin icnt++; streak = 0; end
      if (streak > mx) mx = streak;
      tick();
    end
    chk("t6_max_dstreak", 32'(mx), STARVE_MAX);
    chk("t6_ifetch_served", 32'(icnt > 0), 1);
    iREN = 0; dREN = 0;
    tick();

    // Randomized traffic; the per-cycle model comparison does the checking.
    do_reset();
    acc = 30;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) acc = $urandom_range(2, 60);
      if ($urandom_range(0, 99) < 20) iREN = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 20) dREN = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 99) < 20) dWEN = ($urandom_range(0, 99) < 40);
      iaddr = $urandom(); daddr = $urandom(); dstore = $urandom(); ramload = $urandom();
      r = $urandom_range(0, 99);
      if (r < acc)           ramstate = 2'd2;
      else if (r < acc + 4)  ramstate = 2'd3;
      else if (r < acc + 14) ramstate = 2'd0;
      else                   ramstate = 2'd1;
      if ($urandom_range(0, 999) < 5) begin
        nRST = 1'b0;
        model_reset();
      end else begin
        nRST = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
